// File: rtl/drv_key_pkg.sv
// Shared types and helpers for the debounced key array.
package drv_key_pkg;

    // Per-channel press-tracking state.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHeld = 2'd1,
        StLong = 2'd2
    } chan_state_e;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input longint unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 64'd1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/drv_key_chan.sv
// One key channel: synchronizer, debounce filter, press/hold/repeat tracker.
module drv_key_chan
    import drv_key_pkg::*;
#(
    parameter int unsigned FILTER_TIME = 1_350_000,
    parameter int unsigned LONG_TIME   = 27_000_000,
    parameter int unsigned REPEAT_TIME = 5_400_000,
    parameter logic        KEY_PRESS   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic flag_press,
    output logic flag_release,
    output logic flag_long,
    output logic flag_repeat,
    output logic key_state
);

    localparam int unsigned FiltW = cnt_width(longint'(FILTER_TIME) - 1);
    localparam int unsigned HoldW = cnt_width(longint'(LONG_TIME));
    localparam int unsigned RepW  = cnt_width(longint'(REPEAT_TIME));

    localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_TIME - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_TIME);
    localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_TIME);

    logic [1:0]       sync_q;
    logic             stable_q;
    logic             stable_d;
    logic [FiltW-1:0] filt_q;
    logic [FiltW-1:0] filt_d;
    logic             toggle;
    logic             press_ev;
    logic             release_ev;
    chan_state_e      state_q;
    logic [HoldW-1:0] hold_q;
    logic [HoldW-1:0] hold_inc;
    logic [RepW-1:0]  rep_q;
    logic [RepW-1:0]  rep_inc;

    // Two-flop synchronizer on the raw pin; resets to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{~KEY_PRESS}};
        end else begin
            sync_q <= {sync_q[0], key};
        end
    end

    // Filter: count consecutive disagreeing cycles, any agreement restarts the window.
    always_comb begin
        filt_d = '0;
        toggle = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (filt_q == FiltLast) begin
                toggle = 1'b1;
            end else begin
                filt_d = filt_q + 1'b1;
            end
        end
        stable_d   = stable_q ^ toggle;
        press_ev   = toggle && (sync_q[1] == KEY_PRESS);
        release_ev = toggle && (sync_q[1] != KEY_PRESS);
    end

    // Filter state and debounced level, key_state normalised to 1 = pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q    <= '0;
            stable_q  <= ~KEY_PRESS;
            key_state <= 1'b0;
        end else begin
            filt_q    <= filt_d;
            stable_q  <= stable_d;
            key_state <= (stable_d == KEY_PRESS);
        end
    end

    // Saturating hold increment and repeat increment.
    always_comb begin
        hold_inc = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;
        rep_inc  = rep_q + 1'b1;
    end

    // Press tracker with registered one-cycle flags; release beats any threshold hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            rep_q        <= '0;
            flag_press   <= 1'b0;
            flag_release <= 1'b0;
            flag_long    <= 1'b0;
            flag_repeat  <= 1'b0;
        end else begin
            flag_press   <= 1'b0;
            flag_release <= 1'b0;
            flag_long    <= 1'b0;
            flag_repeat  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    hold_q <= '0;
                    rep_q  <= '0;
                    if (press_ev) begin
                        flag_press <= 1'b1;
                        state_q    <= StHeld;
                    end
                end
                StHeld: begin
                    if (release_ev) begin
                        flag_release <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        hold_q <= hold_inc;
                        if (hold_inc == HoldMax) begin
                            flag_long <= 1'b1;
                            rep_q     <= '0;
                            state_q   <= StLong;
                        end
                    end
                end
                StLong: begin
                    if (release_ev) begin
                        flag_release <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        hold_q <= hold_inc;
                        if (REPEAT_TIME != 0) begin
                            if (rep_inc == RepLast) begin
                                flag_repeat <= 1'b1;
                                rep_q       <= '0;
                            end else begin
                                rep_q <= rep_inc;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: rtl/drv_key_array.sv
// Array of independent debounced key channels.
module drv_key_array
    import drv_key_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 4,
    parameter int unsigned FILTER_TIME = 1_350_000,
    parameter int unsigned LONG_TIME   = 27_000_000,
    parameter int unsigned REPEAT_TIME = 5_400_000,
    parameter logic        KEY_PRESS   = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] flag_press,
    output logic [NUM_KEYS-1:0] flag_release,
    output logic [NUM_KEYS-1:0] flag_long,
    output logic [NUM_KEYS-1:0] flag_repeat,
    output logic [NUM_KEYS-1:0] key_state
);

    // One self-contained channel per key pin.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        drv_key_chan #(
            .FILTER_TIME (FILTER_TIME),
            .LONG_TIME   (LONG_TIME),
            .REPEAT_TIME (REPEAT_TIME),
            .KEY_PRESS   (KEY_PRESS)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .key          (key[i]),
            .flag_press   (flag_press[i]),
            .flag_release (flag_release[i]),
            .flag_long    (flag_long[i]),
            .flag_repeat  (flag_repeat[i]),
            .key_state    (key_state[i])
        );
    end

endmodule
